// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns and width helpers.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package seg7_pkg;

  // All segments dark, active-high sense (before any board polarity inversion).
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Segment patterns {g,f,e,d,c,b,a} for hex digits; entry n is the glyph for nibble n.
  localparam logic [15:0][6:0] SEG_PAT = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  // Counter width able to index n states, never narrower than 1 bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Digit-index width: IDX_W = $clog2(NDIGITS), minimum 1.
  function automatic int idx_w(input int ndigits);
    return width_of(ndigits);
  endfunction

  // Prescaler width: PCNT_W = $clog2(DIV), DIV is at least 2.
  function automatic int pcnt_w(input int div);
    return width_of(div);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to seven-segment glyph, active-high, no polarity handling.
// Latency: combinational.
// Backpressure: none.
// Ports: nib (4-bit value) -> pat (7-bit {g,f,e,d,c,b,a}).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  assign pat = SEG_PAT[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed, double-buffered seven-segment driver for NDIGITS hex digits on one segment bus.
// Latency: outputs registered one cycle behind the scan counters; a load shows within one frame + BLANK_CYCLES + 2.
// Backpressure: none; load is always accepted, repeated loads before a frame boundary overwrite (last wins).
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   data, dp          value/decimal points to show, captured on load (nibble k -> digit k, digit 0 rightmost)
//   load              1-cycle capture strobe
//   lzb               leading-zero blanking enable, sampled live
//   blink_mask        digits that blink (only with SEG7_BLINK_EN defined)
//   seg, seg_dp       shared segment bus {g,f,e,d,c,b,a} and decimal point
//   dig_en            one-hot digit enable
//   frame             pulse on the last cycle of the last digit slot
// Optional feature: define SEG7_BLINK_EN to add blink_mask, BLINK_FRAMES and the blink frame counter.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NDIGITS      = 4,
  parameter int DIV          = 64,
  parameter int BLANK_CYCLES = 2,
  parameter int ACTIVE_LOW   = 0
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   data,
  input  logic [NDIGITS-1:0]     dp,
  input  logic                   load,
  input  logic                   lzb,
`ifdef SEG7_BLINK_EN
  input  logic [NDIGITS-1:0]     blink_mask,
`endif
  output logic [6:0]             seg,
  output logic                   seg_dp,
  output logic [NDIGITS-1:0]     dig_en,
  output logic                   frame
);

  localparam int   IDX_W  = idx_w(NDIGITS);
  localparam int   PCNT_W = pcnt_w(DIV);
  localparam logic INV    = (ACTIVE_LOW != 0);

  // ---------------------------------------------------------------- scan counters
  logic [PCNT_W-1:0] pcnt;
  logic [IDX_W-1:0]  idx;
  logic              pcnt_last;
  logic              idx_last;
  logic              frame_cond;

  assign pcnt_last  = (pcnt == PCNT_W'(DIV - 1));
  assign idx_last   = (idx == IDX_W'(NDIGITS - 1));
  assign frame_cond = pcnt_last & idx_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (pcnt_last) begin
      pcnt <= '0;
      idx  <= idx_last ? '0 : idx + IDX_W'(1);
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

  // ---------------------------------------------------------------- double buffer
  // The display copy only changes on the frame cycle, so a digit never shows a
  // mix of old and new values within one scan.
  logic [4*NDIGITS-1:0] shadow_dat;
  logic [NDIGITS-1:0]   shadow_dp;
  logic [4*NDIGITS-1:0] disp_dat;
  logic [NDIGITS-1:0]   disp_dp;
  logic                 pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_dat <= '0;
      shadow_dp  <= '0;
      disp_dat   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        shadow_dat <= data;
        shadow_dp  <= dp;
      end
      if (frame_cond) begin
        // A load landing on the frame cycle bypasses the shadow so it is not
        // delayed by a whole extra frame.
        if (load) begin
          disp_dat <= data;
          disp_dp  <= dp;
        end else if (pending) begin
          disp_dat <= shadow_dat;
          disp_dp  <= shadow_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- blink phase
  logic blink_off;

`ifdef SEG7_BLINK_EN
  localparam int BC_W = width_of(BLINK_FRAMES);

  logic [BC_W-1:0] bcnt;
  logic            blink_on;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt     <= '0;
      blink_on <= 1'b1;
    end else if (frame_cond) begin
      if (bcnt == BC_W'(BLINK_FRAMES - 1)) begin
        bcnt     <= '0;
        blink_on <= ~blink_on;
      end else begin
        bcnt <= bcnt + BC_W'(1);
      end
    end
  end
`endif

  // ---------------------------------------------------------------- slot selection
  logic [NDIGITS-1:0] dig_sel;
  logic [3:0]         sel_nib;
  logic               sel_dp;
  logic [NDIGITS-1:0] lead_zero;
  logic               run_zero;
  logic               in_blank;
  logic               lz_blank;
  logic [6:0]         pat;

  assign dig_sel = NDIGITS'(1) << idx;
  assign sel_dp  = |(disp_dp & dig_sel);

`ifdef SEG7_BLINK_EN
  assign blink_off = ~blink_on & (|(blink_mask & dig_sel));
`else
  assign blink_off = 1'b0;
`endif

  always_comb begin
    sel_nib = 4'h0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (idx == IDX_W'(k)) sel_nib = disp_dat[4*k +: 4];
    end
  end

  // lead_zero[k]: every display nibble from the leftmost digit down to k is zero.
  always_comb begin
    lead_zero = '0;
    run_zero  = 1'b1;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      run_zero     = run_zero & (disp_dat[4*k +: 4] == 4'h0);
      lead_zero[k] = run_zero;
    end
  end

  assign in_blank = int'(pcnt) < BLANK_CYCLES;
  assign lz_blank = lzb && (idx != '0) && (|(lead_zero & dig_sel));

  seg7_decode u_decode (
    .nib (sel_nib),
    .pat (pat)
  );

  // ---------------------------------------------------------------- output stage
  logic [6:0]         seg_nxt;
  logic               dp_nxt;
  logic [NDIGITS-1:0] dig_nxt;

  // Leading-zero blanking darkens only the glyph (dp stays); blinking darkens both.
  always_comb begin
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b0;
    dig_nxt = '0;
    if (!in_blank) begin
      dig_nxt = dig_sel;
      if (!blink_off) begin
        dp_nxt = sel_dp;
        if (!lz_blank) seg_nxt = pat;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg    <= {7{INV}};
      seg_dp <= INV;
      dig_en <= {NDIGITS{INV}};
      frame  <= 1'b0;
    end else begin
      seg    <= INV ? ~seg_nxt : seg_nxt;
      seg_dp <= INV ? ~dp_nxt  : dp_nxt;
      dig_en <= INV ? ~dig_nxt : dig_nxt;
      frame  <= frame_cond;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: NDIGITS=4, DIV=4, BLANK_CYCLES=1, plus an ACTIVE_LOW=1 twin.
// Latency: n/a. Backpressure: n/a.
// With SEG7_BLINK_EN defined, the blink sequence is also exercised with BLINK_FRAMES=2.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
`ifdef SEG7_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif

  logic [6:0]  seg, seg_a;
  logic        seg_dp, seg_dp_a;
  logic [3:0]  dig_en, dig_en_a;
  logic        frame, frame_a;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NDIGITS(4), .DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(0)
`ifdef SEG7_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk(clk), .reset(reset), .data(data), .dp(dp), .load(load), .lzb(lzb),
`ifdef SEG7_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg(seg), .seg_dp(seg_dp), .dig_en(dig_en), .frame(frame)
  );

  seg7_scan_driver #(
    .NDIGITS(4), .DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1)
`ifdef SEG7_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut_al (
    .clk(clk), .reset(reset), .data(data), .dp(dp), .load(load), .lzb(lzb),
`ifdef SEG7_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg(seg_a), .seg_dp(seg_dp_a), .dig_en(dig_en_a), .frame(frame_a)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k, input logic lz,
                                         input logic [3:0] boff);
    if (boff[k]) return 7'h00;
    if (lz && k != 0 && (v >> (4*k)) == 16'h0) return 7'h00;
    return glyph(v[4*k +: 4]);
  endfunction

  // One-cycle load, issued at a falling edge so the next rising edge captures it.
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    data = v;
    dp   = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = frame;
    end
    chk({tag, "_frame_seen"}, frame, 1'b1);
  endtask

  // Called at the falling edge where frame is high; checks every cycle of the next
  // frame and optionally issues loads at chosen cycles (-1 = none).
  task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] dv,
                             input logic lz, input logic [3:0] boff,
                             input int la1, input logic [15:0] lv1,
                             input int la2, input logic [15:0] lv2);
    for (int j = 0; j < 16; j++) begin
      int s = j / 4;
      int p = j % 4;
      @(negedge clk);
      chk($sformatf("%s_j%0d_frame", tag, j), frame, (j == 15));
      if (p == 0) begin
        chk($sformatf("%s_j%0d_blank_dig", tag, j), dig_en, 4'b0000);
        chk($sformatf("%s_j%0d_blank_seg", tag, j), seg, 7'h00);
      end else begin
        chk($sformatf("%s_j%0d_dig", tag, j), dig_en, 4'b0001 << s);
        chk($sformatf("%s_j%0d_seg", tag, j), seg, exp_seg(v, s, lz, boff));
        chk($sformatf("%s_j%0d_dp", tag, j), seg_dp, boff[s] ? 1'b0 : dv[s]);
      end
      if (j == la1) begin
        data = lv1; dp = '0; load = 1'b1;
      end else if (j == la2) begin
        data = lv2; dp = '0; load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
  endtask

  initial begin
    int cnt;
    bit seen;

    // Reset state on both polarities.
    repeat (3) @(negedge clk);
    chk("rst_seg", seg, 7'h00);
    chk("rst_dp", seg_dp, 1'b0);
    chk("rst_dig", dig_en, 4'h0);
    chk("rst_frame", frame, 1'b0);
    chk("rst_seg_al", seg_a, 7'h7F);
    chk("rst_dp_al", seg_dp_a, 1'b1);
    chk("rst_dig_al", dig_en_a, 4'hF);
    chk("rst_frame_al", frame_a, 1'b0);
    reset = 1'b0;
    wait_frame("boot");

    // Basic display with a decimal point on digit 2.
    do_load(16'h1234, 4'b0100);
    wait_frame("t1");
    check_frame("t1", 16'h1234, 4'b0100, 1'b0, 4'h0, -1, 16'h0, -1, 16'h0);

    // Leading-zero blanking; dp survives on a blanked digit.
    lzb = 1'b1;
    do_load(16'h0050, 4'b1000);
    wait_frame("t3a");
    check_frame("t3a", 16'h0050, 4'b1000, 1'b1, 4'h0, -1, 16'h0, -1, 16'h0);
    do_load(16'h0000, 4'b0000);
    wait_frame("t3b");
    check_frame("t3b", 16'h0000, 4'b0000, 1'b1, 4'h0, -1, 16'h0, -1, 16'h0);

    // Mid-frame loads leave the frame untouched; last one wins at the boundary.
    lzb = 1'b0;
    check_frame("t4a", 16'h0000, 4'b0000, 1'b0, 4'h0, 3, 16'hAAAA, 7, 16'h5555);
    // Load on the frame cycle itself shows in the very next frame.
    check_frame("t4b", 16'h5555, 4'b0000, 1'b0, 4'h0, 14, 16'hF0F1, -1, 16'h0);
    check_frame("t4c", 16'hF0F1, 4'b0000, 1'b0, 4'h0, -1, 16'h0, -1, 16'h0);

    // Reset in the middle of a lit slot.
    @(negedge clk);
    @(negedge clk);
    chk("t5_pre_seg", seg, 7'h06);
    chk("t5_pre_seg_al", seg_a, 7'h79);
    chk("t5_pre_dig_al", dig_en_a, 4'b1110);
    reset = 1'b1;
    #1;
    chk("t5_rst_seg_al", seg_a, 7'h7F);
    chk("t5_rst_dp_al", seg_dp_a, 1'b1);
    chk("t5_rst_dig_al", dig_en_a, 4'hF);
    chk("t5_rst_dig", dig_en, 4'h0);
    chk("t5_rst_seg", seg, 7'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rel_blank_dig", dig_en, 4'h0);
    chk("t5_rel_blank_dig_al", dig_en_a, 4'hF);
    @(negedge clk);
    chk("t5_rel_dig", dig_en, 4'b0001);
    chk("t5_rel_seg", seg, 7'h3F);
    chk("t5_rel_seg_al", seg_a, 7'h40);
    chk("t5_rel_dig_al", dig_en_a, 4'b1110);
    cnt  = 2;
    seen = 1'b0;
    while (cnt < 40 && !seen) begin
      @(negedge clk);
      cnt++;
      seen = frame;
    end
    chk("t5_first_frame_cycle", cnt, 16);
    chk("t5_first_frame_al", frame_a, 1'b1);

`ifdef SEG7_BLINK_EN
    // Blink phase: on for frames 0-1 after reset, off for 2-3, on again at 4.
    blink_mask = 4'b0010;
    check_frame("t6f1", 16'h0000, 4'b0000, 1'b0, 4'b0000, -1, 16'h0, -1, 16'h0);
    check_frame("t6f2", 16'h0000, 4'b0000, 1'b0, 4'b0010, -1, 16'h0, -1, 16'h0);
    check_frame("t6f3", 16'h0000, 4'b0000, 1'b0, 4'b0010, -1, 16'h0, -1, 16'h0);
    check_frame("t6f4", 16'h0000, 4'b0000, 1'b0, 4'b0000, -1, 16'h0, -1, 16'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
